// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its multi-cycle mul/div sequencer.
//   - ALU_control encodings {A_invert, B_invert, operation[1:0]}
//   - operation select for the sequencer (MULU / DIVU)
//   - sequencer FSM state encoding
package alu_pkg;

  localparam int ALU_W = 32;

  // ALU_control values. B_invert doubles as the carry-in, so SUB = ~B + 1.
  localparam logic [3:0] ALU_CTL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTL_SLT = 4'b0111;

  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of shift-add multiply / restoring divide, given the ALU's
// answer for this cycle.
// Ports:
//   op          0 = MULU, 1 = DIVU
//   p_hi, p_lo  current partial product / {partial remainder, dividend-quotient}
//   alu_result  ALU result for the operands the top drives this cycle
//   alu_cout    ALU carry out of the MSB
//   div_s       shifted partial remainder fed to ALU src1 during DIVU
//   p_hi_next   next P_hi
//   p_lo_next   next P_lo
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         op,
  input  logic [W-1:0] p_hi,
  input  logic [W-1:0] p_lo,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout,
  output logic [W-1:0] div_s,
  output logic [W-1:0] p_hi_next,
  output logic [W-1:0] p_lo_next
);

  logic div_ok;

  // The remainder shifted left by one; its true width is W+1 bits, with
  // p_hi[W-1] being the bit that falls off the top.
  assign div_s = {p_hi[W-2:0], p_lo[W-1]};

  // The subtraction fits if the dropped top bit is set (the W+1-bit value
  // is certainly >= divisor) or the W-bit subtract produced no borrow.
  assign div_ok = p_hi[W-1] | alu_cout;

  always_comb begin
    p_hi_next = p_hi;
    p_lo_next = p_lo;
    if (op == OP_DIVU) begin
      if (div_ok) begin
        p_hi_next = alu_result;
        p_lo_next = {p_lo[W-2:0], 1'b1};
      end else begin
        p_hi_next = div_s;
        p_lo_next = {p_lo[W-2:0], 1'b0};
      end
    end else begin
      // {cout, sum, P_lo} >> 1: the carry becomes the new top bit and the
      // sum's LSB slides into P_lo as the multiplier bit is consumed.
      p_hi_next = {alu_cout, alu_result[W-1:1]};
      p_lo_next = {alu_result[0], p_lo[W-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer running unsigned MULU (shift-add) and DIVU
// (restoring) on the shared ripple ALU, one ALU step per cycle.
// Fixed latency: start accepted at cycle 0 -> done pulse at cycle W+1.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start, op            request (accepted only in IDLE), 0=MULU / 1=DIVU
//   src_a, src_b         multiplicand/dividend, multiplier/divisor
//   busy                 high in RUN and DONE
//   done                 one-cycle pulse, hi/lo valid
//   hi, lo               MULU: product high/low; DIVU: remainder/quotient
//   alu_src1, alu_src2   ALU operands (combinational from state/regs)
//   alu_ctrl             ALU_control
//   alu_result, alu_cout ALU answer for the current operands
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int         W       = 32,
  parameter logic [3:0] CTL_ADD = ALU_CTL_ADD,
  parameter logic [3:0] CTL_SUB = ALU_CTL_SUB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] alu_src1,
  output logic [W-1:0] alu_src2,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          op_reg;
  logic [W-1:0]  opnd_reg;   // multiplicand (MULU) or divisor (DIVU)
  logic [W-1:0]  p_hi_reg;
  logic [W-1:0]  p_lo_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [W-1:0]  hi_reg;
  logic [W-1:0]  lo_reg;

  logic [W-1:0]  div_s;
  logic [W-1:0]  p_hi_next;
  logic [W-1:0]  p_lo_next;

  alu_muldiv_step #(
    .W (W)
  ) u_step (
    .op         (op_reg),
    .p_hi       (p_hi_reg),
    .p_lo       (p_lo_reg),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .div_s      (div_s),
    .p_hi_next  (p_hi_next),
    .p_lo_next  (p_lo_next)
  );

  // ALU drive depends only on registered state, never on start, so the
  // core's ALU mux sees no combinational path from its own request.
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = 4'b0000;
    if (state_reg == ST_RUN) begin
      if (op_reg == OP_DIVU) begin
        alu_ctrl = CTL_SUB;
        alu_src1 = div_s;
        alu_src2 = opnd_reg;
      end else begin
        alu_ctrl = CTL_ADD;
        alu_src1 = p_hi_reg;
        alu_src2 = p_lo_reg[0] ? opnd_reg : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_MULU;
      opnd_reg  <= '0;
      p_hi_reg  <= '0;
      p_lo_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            op_reg    <= op;
            p_hi_reg  <= '0;
            // MULU walks the multiplier through P_lo; DIVU shifts the
            // dividend out of P_lo while the quotient shifts in behind it.
            if (op == OP_DIVU) begin
              opnd_reg <= src_b;
              p_lo_reg <= src_a;
            end else begin
              opnd_reg <= src_a;
              p_lo_reg <= src_b;
            end
          end
        end

        ST_RUN: begin
          p_hi_reg <= p_hi_next;
          p_lo_reg <= p_lo_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Capture the result of the final step directly so hi/lo are
            // valid in the same cycle done goes high.
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            hi_reg    <= p_hi_next;
            lo_reg    <= p_lo_next;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq paired with a behavioural 32-bit ALU.
// Expected results come from plain '*', '/' and '%' on the operands.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] alu_src1;
  logic [W-1:0] alu_src2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(
    .W (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  // Ripple ALU: {A_invert, B_invert, operation}, carry-in = B_invert.
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W:0]   alu_sum;

  always_comb begin
    alu_a      = alu_ctrl[3] ? ~alu_src1 : alu_src1;
    alu_b      = alu_ctrl[2] ? ~alu_src2 : alu_src2;
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ctrl[2]};
    alu_cout   = alu_sum[W];
    alu_result = '0;
    case (alu_ctrl[1:0])
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a | alu_b;
      2'b10:   alu_result = alu_sum[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, alu_sum[W-1]};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [2*W-1:0] p;
    if (o == OP_MULU) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      rh = p[2*W-1:W];
      rl = p[W-1:0];
    end else if (b == '0) begin
      rh = a;
      rl = '1;
    end else begin
      rh = a % b;
      rl = a / b;
    end
  endtask

  // Called at a falling edge; returns at the falling edge one cycle after DONE.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    int n;
    ref_model(o, a, b, eh, el);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("ctrl_run", alu_ctrl, (o == OP_DIVU) ? ALU_CTL_SUB : ALU_CTL_ADD);
    chk("busy_run", busy, 1);
    while (!done && n < 100) begin
      // Operands are sampled only with start; scramble them mid-run.
      src_a = $urandom;
      src_b = $urandom;
      op    = $urandom_range(0, 1);
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 1);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("busy_done", busy, 1);
    $display("op=%s a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h cyc=%0d",
             (o == OP_DIVU) ? "DIVU" : "MULU", a, b, hi, lo, n);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("ctrl_idle", alu_ctrl, 0);
    chk("hi_hold", hi, eh);
    chk("lo_hold", lo, el);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] eh;
    logic [W-1:0] el;
    int dones;
    int first_done;
    int k;

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_src1", alu_src1, 0);
    chk("rst_src2", alu_src2, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    rst = 1'b0;

    run_op(OP_MULU, 32'h0000_0003, 32'h0000_0005);
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'h1234_5678, 32'h0000_0000);
    run_op(OP_MULU, 32'h0000_0000, 32'hDEAD_BEEF);
    run_op(OP_DIVU, 32'd5, 32'd9);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? W'($urandom_range(1, 255)) : W'($urandom);
      run_op(W'($urandom_range(0, 1)) != 0 ? OP_DIVU : OP_MULU, ra, rb);
    end

    // start held high: one done inside 40 cycles, the re-start is taken the
    // cycle after DONE and completes 33 cycles later.
    ref_model(OP_DIVU, 32'd100, 32'd7, eh, el);
    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    dones = 0;
    first_done = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first_done == 0) first_done = k;
      end
      if (k == 34) chk("held_idle_busy", busy, 0);
      if (k == 35) chk("held_restart_busy", busy, 1);
    end
    start = 1'b0;
    chk("held_dones", dones, 1);
    chk("held_first_cyc", first_done, W + 1);
    while (!done && k < 150) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    chk("held_second_cyc", k, 2 * (W + 1) + 1);
    chk("held_hi", hi, eh);
    chk("held_lo", lo, el);
    $display("op=DIVU held a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h cyc=%0d",
             src_a, src_b, hi, lo, k);
    @(negedge clk);

    // Reset mid-run.
    start = 1'b1;
    op    = OP_MULU;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_ctrl", alu_ctrl, 0);
    chk("midrst_src1", alu_src1, 0);
    $display("op=RST busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
    rst = 1'b0;
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'h7);
    run_op(OP_DIVU, $urandom, W'($urandom_range(1, 1000)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
